// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcodes, the D-channel beat record, and the alignment rule.
package tl_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGICAL     = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] HINT        = 3'd5;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam int TL_SRC_W  = 8;
  localparam int TL_DATA_W = 32;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic                 denied;
    logic                 corrupt;
    logic [TL_DATA_W-1:0] data;
  } tl_d_beat_t;

  // Sizes above a word are never aligned on a 32-bit bus, so they report misaligned.
  function automatic logic tl_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      3'd0:    return 1'b1;
      3'd1:    return !addr_lo[0];
      3'd2:    return addr_lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tl_ul_ram_responder_if.sv
// TileLink-UL A/D channel bundle; master drives A and d_ready, slave drives D and a_ready.
interface tl_ul_ram_responder_if #(
  parameter int ADDR_W = 25,
  parameter int SRC_W  = 8,
  parameter int DATA_W = 32
);
  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [2:0]            a_size;
  logic [SRC_W-1:0]      a_source;
  logic [ADDR_W-1:0]     a_address;
  logic [DATA_W/8-1:0]   a_mask;
  logic [DATA_W-1:0]     a_data;

  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [1:0]            d_param;
  logic [2:0]            d_size;
  logic [SRC_W-1:0]      d_source;
  logic                  d_denied;
  logic                  d_corrupt;
  logic [DATA_W-1:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
  );
endinterface

// File: rtl/tl_resp_fifo.sv
// Two-entry response queue for TL responders; head entry is driven straight from storage.
module tl_resp_fifo
  import tl_pkg::*;
#(
  parameter type beat_t = tl_d_beat_t
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  i_push,
  input  beat_t i_beat,
  input  logic  i_pop,
  output beat_t o_head,
  output logic  o_full,
  output logic  o_empty
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage is cleared on reset so an idle head presents an all-zero beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_beat;
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL manager terminating Get/PutFull/PutPartial on a word RAM, with in-order D responses.
module tl_ul_ram_responder
  import tl_pkg::*;
#(
  parameter int                ADDR_W = 25,
  parameter int                SRC_W  = 8,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 256,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input logic                  clock,
  input logic                  reset,
  tl_ul_ram_responder_if.slave bus
);

  localparam int                MASK_W = DATA_W / 8;
  localparam int                WORD_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   SPAN   = (ADDR_W + 1)'(DEPTH * 4);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_a_fire;
  logic              w_d_fire;
  logic [ADDR_W-1:0] w_offset;
  logic              w_hit;
  logic              w_is_get;
  logic              w_is_put;
  logic              w_legal;
  logic [WORD_W-1:0] w_word;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  tl_d_beat_t        w_beat;
  tl_d_beat_t        w_head;
  logic              w_unused;

  assign w_unused = ^bus.a_param;

  assign bus.a_ready = !w_fifo_full;
  assign w_a_fire    = bus.a_valid && bus.a_ready;
  assign w_d_fire    = bus.d_valid && bus.d_ready;

  // Offset wraps at ADDR_W bits, so addresses below BASE land far out of range and miss.
  assign w_offset = bus.a_address - BASE;
  assign w_hit    = {1'b0, w_offset} < SPAN;
  assign w_word   = w_offset[WORD_W+1:2];
  assign w_is_get = (bus.a_opcode == GET);
  assign w_is_put = (bus.a_opcode == PUT_FULL) || (bus.a_opcode == PUT_PARTIAL);
  assign w_legal  = w_hit && (bus.a_size <= 3'd2) &&
                    tl_aligned(bus.a_size, bus.a_address[1:0]) && (w_is_get || w_is_put);

  always_comb begin
    w_beat         = '0;
    w_beat.size    = bus.a_size;
    w_beat.source  = TL_SRC_W'(bus.a_source);
    w_beat.denied  = !w_legal;
    if (w_is_get) begin
      w_beat.opcode  = ACCESS_ACK_DATA;
      w_beat.corrupt = !w_legal;
      if (w_legal) begin
        w_beat.data = TL_DATA_W'(r_mem[w_word]);
      end
    end else begin
      w_beat.opcode = ACCESS_ACK;
    end
  end

  // Writes land on the fire edge, so a Get fired on the next cycle already sees them.
  always_ff @(posedge clock) begin
    if (!reset && w_a_fire && w_is_put && w_legal) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (bus.a_mask[i]) begin
          r_mem[w_word][8*i +: 8] <= bus.a_data[8*i +: 8];
        end
      end
    end
  end

  tl_resp_fifo #(
    .beat_t (tl_d_beat_t)
  ) u_resp_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_a_fire),
    .i_beat  (w_beat),
    .i_pop   (w_d_fire),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign bus.d_valid   = !w_fifo_empty;
  assign bus.d_opcode  = w_head.opcode;
  assign bus.d_param   = 2'b00;
  assign bus.d_size    = w_head.size;
  assign bus.d_source  = SRC_W'(w_head.source);
  assign bus.d_denied  = w_head.denied;
  assign bus.d_corrupt = w_head.corrupt;
  assign bus.d_data    = DATA_W'(w_head.data);

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Directed bench for tl_ul_ram_responder: per-cycle queue/RAM model plus literal checks on logged beats.
module tb_tl_ul_ram_responder;
  import tl_pkg::*;

  localparam int                ADDR_W = 25;
  localparam int                SRC_W  = 8;
  localparam int                DATA_W = 32;
  localparam int                DEPTH  = 256;
  localparam logic [ADDR_W-1:0] BASE   = '0;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tl_ul_ram_responder_if #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .DATA_W(DATA_W)) bus ();

  tl_ul_ram_responder #(
    .ADDR_W(ADDR_W), .SRC_W(SRC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(BASE)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [7:0]  src;
    logic        den;
    logic        cor;
    logic [31:0] data;
    bit          dknown;
    int          cyc;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        got[$];
  logic [31:0] m_ram[int];
  int          last_fire;
  int          lowcnt;
  bit          stream_on;
  bit          done3;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endfunction

  // Reference behaviour of one accepted A beat: expected D beat, plus the RAM side effect.
  function automatic rsp_t model(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                                 input logic [3:0] mask, input logic [31:0] data,
                                 input logic [2:0] size, input logic [7:0] src);
    rsp_t              r;
    logic [ADDR_W-1:0] off;
    logic [31:0]       word;
    bit                legal;
    int                w;
    off   = addr - BASE;
    w     = int'(off) / 4;
    legal = (int'(off) < DEPTH * 4) && (size <= 2) &&
            ((int'(addr) % (1 << size)) == 0) && (op == 0 || op == 1 || op == 4);
    r.src = src; r.size = size; r.den = !legal; r.cor = 1'b0;
    r.data = 32'h0; r.dknown = 1'b1; r.cyc = 0;
    if (op == 3'd4) begin
      r.op  = 3'd1;
      r.cor = !legal;
      if (legal) begin
        if (m_ram.exists(w)) r.data = m_ram[w];
        else r.dknown = 1'b0;
      end
    end else begin
      r.op = 3'd0;
      if (legal) begin
        word = m_ram.exists(w) ? m_ram[w] : 32'h0;
        for (int i = 0; i < 4; i++) if (mask[i]) word[8*i +: 8] = data[8*i +: 8];
        m_ram[w] = word;
      end
    end
    return r;
  endfunction

  task automatic monitor();
    rsp_t e;
    rsp_t g;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        continue;
      end
      if (stream_on && !bus.a_ready) lowcnt++;
      chk("handshake{d_valid,a_ready}", {bus.d_valid, bus.a_ready},
          {(exp_q.size() != 0), (exp_q.size() < 2)});
      if (bus.d_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q[0];
        total++;
        if (bus.d_opcode !== e.op || bus.d_param !== 2'b00 || bus.d_size !== e.size ||
            bus.d_source !== e.src || bus.d_denied !== e.den || bus.d_corrupt !== e.cor ||
            (e.dknown && bus.d_data !== e.data)) begin
          bad++;
          $display("FAIL d_beat: got op=%0d src=0x%0h den=%b cor=%b data=0x%08h want op=%0d src=0x%0h den=%b cor=%b data=0x%08h",
                   bus.d_opcode, bus.d_source, bus.d_denied, bus.d_corrupt, bus.d_data,
                   e.op, e.src, e.den, e.cor, e.data);
        end
        if (bus.d_ready) begin
          g.op = bus.d_opcode; g.size = bus.d_size; g.src = bus.d_source;
          g.den = bus.d_denied; g.cor = bus.d_corrupt; g.data = bus.d_data;
          g.dknown = 1'b1; g.cyc = cyc;
          got.push_back(g);
          void'(exp_q.pop_front());
        end
      end
      if (bus.a_valid === 1'b1 && bus.a_ready === 1'b1)
        exp_q.push_back(model(bus.a_opcode, bus.a_address, bus.a_mask, bus.a_data,
                              bus.a_size, bus.a_source));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [2:0] size, input logic [7:0] src);
    int n;
    n = 0;
    bus.a_valid = 1'b1; bus.a_opcode = op; bus.a_param = 3'd0; bus.a_size = size;
    bus.a_source = src; bus.a_address = addr; bus.a_mask = mask; bus.a_data = data;
    forever begin
      @(negedge clk);
      if (bus.a_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        chk("a_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    last_fire = cyc;
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.d_valid === 1'b1) && n < 100) begin
      tick(1);
      n++;
    end
    chk("drain_within_budget", 64'(n < 100), 64'd1);
  endtask

  task automatic pin(input string name, input int idx, input logic [2:0] op, input logic den,
                     input logic cor, input logic [7:0] src, input logic [31:0] data);
    if (idx >= got.size())
      chk({name, "_missing"}, 64'(got.size()), 64'(idx + 1));
    else
      chk(name, {got[idx].op, got[idx].den, got[idx].cor, got[idx].src, got[idx].data},
          {op, den, cor, src, data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int first;
    int hits;
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_opcode = 3'd0; bus.a_param = 3'd0; bus.a_size = 3'd0;
    bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
    bus.d_ready = 1'b1;
    stream_on = 1'b0; lowcnt = 0; done3 = 1'b0;
    fork
      monitor();
    join_none
    tick(2);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_a_ready", bus.a_ready, 1);
    chk("rst_d_fields", {bus.d_opcode, bus.d_source, bus.d_denied, bus.d_corrupt, bus.d_data}, 0);
    tick(1);

    // PutFull then Get on the very next cycle
    n0 = got.size();
    send(PUT_FULL, 25'h10, 32'hDEADBEEF, 4'hF, 3'd2, 8'h5A);
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h5B);
    drain();
    pin("putfull_ack", n0, 3'd0, 1'b0, 1'b0, 8'h5A, 32'h0);
    pin("get_after_put", n0 + 1, 3'd1, 1'b0, 1'b0, 8'h5B, 32'hDEADBEEF);

    // PutPartial on byte lane 1
    n0 = got.size();
    send(PUT_PARTIAL, 25'h10, 32'h00001100, 4'h2, 3'd2, 8'h20);
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h21);
    drain();
    pin("putpartial_ack", n0, 3'd0, 1'b0, 1'b0, 8'h20, 32'h0);
    pin("get_after_partial", n0 + 1, 3'd1, 1'b0, 1'b0, 8'h21, 32'hDEAD11EF);

    // Out of range, unsupported opcode, misaligned
    n0 = got.size();
    send(GET, 25'h400, 32'h0, 4'hF, 3'd2, 8'h30);
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h31);
    send(ARITH, 25'h10, 32'h0, 4'hF, 3'd2, 8'h32);
    send(GET, 25'h12, 32'h0, 4'hF, 3'd2, 8'h33);
    send(PUT_FULL, 25'h3FC, 32'hCAFEF00D, 4'hF, 3'd2, 8'h34);
    send(GET, 25'h3FC, 32'h0, 4'hF, 3'd2, 8'h35);
    drain();
    pin("get_miss", n0, 3'd1, 1'b1, 1'b1, 8'h30, 32'h0);
    pin("ram_unchanged", n0 + 1, 3'd1, 1'b0, 1'b0, 8'h31, 32'hDEAD11EF);
    pin("arith_denied", n0 + 2, 3'd0, 1'b1, 1'b0, 8'h32, 32'h0);
    pin("misaligned_denied", n0 + 3, 3'd1, 1'b1, 1'b1, 8'h33, 32'h0);
    pin("last_word_get", n0 + 5, 3'd1, 1'b0, 1'b0, 8'h35, 32'hCAFEF00D);

    // Back-pressure: third request stalls until D drains
    bus.d_ready = 1'b0;
    n0 = got.size();
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h01);
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h02);
    fork
      begin
        send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h03);
        done3 = 1'b1;
      end
    join_none
    tick(3);
    @(negedge clk);
    chk("stall_a_ready", bus.a_ready, 0);
    chk("stall_no_d", 64'(got.size() - n0), 64'd0);
    @(posedge clk);
    #1;
    bus.d_ready = 1'b1;
    for (int i = 0; i < 20 && !done3; i++) tick(1);
    chk("stall_src3_accepted", done3, 1);
    drain();
    pin("order_1", n0, 3'd1, 1'b0, 1'b0, 8'h01, 32'hDEAD11EF);
    pin("order_2", n0 + 1, 3'd1, 1'b0, 1'b0, 8'h02, 32'hDEAD11EF);
    pin("order_3", n0 + 2, 3'd1, 1'b0, 1'b0, 8'h03, 32'hDEAD11EF);
    if (got.size() >= n0 + 3)
      chk("order_one_per_cycle", {32'(got[n0+1].cyc - got[n0].cyc), 32'(got[n0+2].cyc - got[n0+1].cyc)},
          {32'd1, 32'd1});

    // Streaming: 16 Gets, 16 D beats over 17 cycles
    n0 = got.size();
    lowcnt = 0;
    stream_on = 1'b1;
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h40);
    first = last_fire;
    for (int i = 1; i < 16; i++) send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'(8'h40 + i));
    stream_on = 1'b0;
    drain();
    chk("stream_count", 64'(got.size() - n0), 64'd16);
    chk("stream_a_ready_low", 64'(lowcnt), 64'd0);
    chk("stream_a_span", 64'(last_fire - first), 64'd15);
    if (got.size() >= n0 + 16)
      chk("stream_d_span", {32'(got[n0].cyc - first), 32'(got[n0+15].cyc - first)}, {32'd1, 32'd16});
    pin("stream_last", n0 + 15, 3'd1, 1'b0, 1'b0, 8'h4F, 32'hDEAD11EF);

    // Reset drops pending responses and blocks a coinciding Put
    bus.d_ready = 1'b0;
    n0 = got.size();
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h61);
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h62);
    @(negedge clk);
    chk("pre_reset_full", {bus.d_valid, bus.a_ready}, 2'b10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_d_valid", bus.d_valid, 0);
    chk("post_reset_a_ready", bus.a_ready, 1);
    @(posedge clk);
    #1;
    bus.d_ready = 1'b1;
    rst = 1'b1;
    send(PUT_FULL, 25'h10, 32'h12345678, 4'hF, 3'd2, 8'h70);
    rst = 1'b0;
    send(GET, 25'h10, 32'h0, 4'hF, 3'd2, 8'h71);
    drain();
    pin("put_during_reset_ignored", n0, 3'd1, 1'b0, 1'b0, 8'h71, 32'hDEAD11EF);
    hits = 0;
    for (int i = n0; i < got.size(); i++)
      if (got[i].src == 8'h61 || got[i].src == 8'h62 || got[i].src == 8'h70) hits++;
    chk("reset_dropped_pending", 64'(hits), 64'd0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
